// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD bus arbiter.
// Holds the FSM state enum, the power-on command list and cycle defaults.
package lcd_pkg;

    typedef enum logic [2:0] {
        INIT_WAIT,
        SETUP,
        PULSE,
        WAIT,
        IDLE
    } lcd_state_e;

    // Element 0 is sent first: function set, display on, clear, entry mode.
    localparam logic [3:0][7:0] INIT_CMDS = {
        8'h06,
        8'h01,
        8'h0C,
        8'h38
    };

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    localparam int unsigned PWR_CYC_DEF   = 1500;
    localparam int unsigned E_CYC_DEF     = 1;
    localparam int unsigned EXEC_CYC_DEF  = 4;
    localparam int unsigned CLEAR_CYC_DEF = 160;

    function automatic int unsigned max4(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c,
        input int unsigned d
    );
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Clear and both return-home encodings (0x02, 0x03) need the long wait.
    function automatic logic is_long_cmd(
        input logic       rs,
        input logic [7:0] b
    );
        return !rs && ((b == CMD_CLEAR) ||
                       (b[7:1] == CMD_HOME[7:1]));
    endfunction

endpackage

// File: rtl/lcd_rr_arb2.sv
// Two-input round-robin grant for the LCD bus requesters.
// Ports: clk, rst (async, active-low), req_i[1:0], advance_i, grant_o[1:0].
module lcd_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);

    logic last_q;
    logic last_d;

    // On a tie the port that was not served last wins.
    always_comb begin
        grant_o = 2'b00;
        if (req_i == 2'b11) begin
            grant_o = last_q ? 2'b01 : 2'b10;
        end else if (req_i[0]) begin
            grant_o = 2'b01;
        end else if (req_i[1]) begin
            grant_o = 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (advance_i && (grant_o != 2'b00)) begin
            last_d = grant_o[1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Shares one HD44780 bus between two writers; runs power-on init first.
// Ports: clk, rst (async low), req/req_rs/req_data in, ack/ready/RS/RW/E/data out.
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES = PWR_CYC_DEF,
    parameter int unsigned E_CYCLES       = E_CYC_DEF,
    parameter int unsigned EXEC_CYCLES    = EXEC_CYC_DEF,
    parameter int unsigned CLEAR_CYCLES   = CLEAR_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  req_rs,
    input  logic [15:0] req_data,
    output logic [1:0]  ack,
    output logic        ready,
    output logic        RS,
    output logic        RW,
    output logic        E,
    output logic [7:0]  data
);

    localparam int unsigned CNT_W = $clog2(max4(
        POWERUP_CYCLES, E_CYCLES,
        EXEC_CYCLES, CLEAR_CYCLES)) + 1;

    localparam logic [CNT_W-1:0] PWR_LD   = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] E_LD     = CNT_W'(E_CYCLES - 1);
    localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_CYCLES - 1);

    lcd_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;
    logic [1:0]       idx_d;
    logic [1:0]       ack_q;
    logic             ready_q;
    logic             rs_q;
    logic             e_q;
    logic [7:0]       data_q;

    logic [1:0]       grant;
    logic             arb_adv;
    logic [7:0]       gnt_byte;
    logic             gnt_rs;

    assign arb_adv  = (state_q == IDLE);
    assign idx_d    = idx_q + 2'd1;
    assign gnt_byte = grant[1] ? req_data[15:8] : req_data[7:0];
    assign gnt_rs   = grant[1] ? req_rs[1] : req_rs[0];

    lcd_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req),
        .advance_i (arb_adv),
        .grant_o   (grant)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT_WAIT;
            cnt_q   <= PWR_LD;
            idx_q   <= 2'd0;
            ack_q   <= 2'b00;
            ready_q <= 1'b0;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            ack_q <= 2'b00;
            unique case (state_q)
                INIT_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= SETUP;
                        rs_q    <= 1'b0;
                        data_q  <= INIT_CMDS[0];
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                SETUP: begin
                    state_q <= PULSE;
                    e_q     <= 1'b1;
                    cnt_q   <= E_LD;
                end
                PULSE: begin
                    if (cnt_q == '0) begin
                        state_q <= WAIT;
                        e_q     <= 1'b0;
                        cnt_q   <= is_long_cmd(rs_q, data_q)
                                   ? CLEAR_LD : EXEC_LD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (ready_q) begin
                        state_q <= IDLE;
                    end else if (idx_q == 2'd3) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        state_q <= SETUP;
                        idx_q   <= idx_d;
                        rs_q    <= 1'b0;
                        data_q  <= INIT_CMDS[idx_d];
                    end
                end
                IDLE: begin
                    if (grant != 2'b00) begin
                        state_q <= SETUP;
                        ack_q   <= grant;
                        rs_q    <= gnt_rs;
                        data_q  <= gnt_byte;
                    end
                end
                default: begin
                    state_q <= INIT_WAIT;
                    cnt_q   <= PWR_LD;
                end
            endcase
        end
    end

    assign ack   = ack_q;
    assign ready = ready_q;
    assign RS    = rs_q;
    assign RW    = 1'b0;
    assign E     = e_q;
    assign data  = data_q;

endmodule

// File: doc/lcd_bus_arbiter.md
# lcd_bus_arbiter

Shares the single HD44780-style character LCD bus (RS, RW, E, 8-bit data) between two independent write requesters, such as the encoder-1 and encoder-2 parameter display writers. After reset it runs a fixed power-on initialisation sequence. It then serves character and command writes round-robin, generating E pulses and per-command execution waits. It runs on the divided ~97.656 kHz LCD clock (10.24 µs period) and drives the LCD pins of GPIO_0 directly.

## Interface
- POWERUP_CYCLES, 1500, idle cycles between reset release and the first init command (≈15.4 ms).
- E_CYCLES, 1, cycles E is held high per write.
- EXEC_CYCLES, 4, post-pulse wait for normal commands and data (≈41 µs).
- CLEAR_CYCLES, 160, post-pulse wait for clear (0x01) and return-home (0x02/0x03) commands (≈1.64 ms).
- clk  input  1  LCD clock; all state changes on its rising edge.
- rst  input  1  reset; asynchronous, active-low.
- req  input  2  per-requester write request; held until acked.
- req_rs  input  2  per-requester RS: 1 = data, 0 = command.
- req_data  input  16  per-requester byte; requester n uses bits [8n+7:8n].
- ack  output  2  one-cycle accept pulse to the granted requester.
- ready  output  1  high once initialisation is complete.
- RS  output  1  LCD register select.
- RW  output  1  LCD read/write; constant 0.
- E  output  1  LCD enable; LCD latches on its falling edge.
- data  output  8  LCD data bus.

## Operation
- States: INIT_WAIT, SETUP, PULSE, WAIT, IDLE.
- Reset values: E=0, RS=0, RW=0, data=0x00, ack=00, ready=0, state=INIT_WAIT, init index=0, last_grant=1.
- INIT_WAIT: counts POWERUP_CYCLES cycles, then loads init command 0 and enters SETUP.
- Init commands, in order, all with RS=0 and no ack: 0x38 (8-bit, 2-line), 0x0C (display on), 0x01 (clear), 0x06 (entry increment).
- SETUP: 1 cycle. RS and data are driven from the latched request; E=0.
- PULSE: E=1 for E_CYCLES cycles; RS and data are held.
- WAIT: E=0; RS and data are held. The wait lasts CLEAR_CYCLES if RS=0 and the byte is 0x01, 0x02 or 0x03; otherwise it lasts EXEC_CYCLES.
- End of WAIT:
  - During init, go to the next init command's SETUP.
  - After the last init command, go to IDLE and set ready=1.
  - Otherwise, go to IDLE.
- IDLE with exactly one req bit set: latch that requester's rs and byte, and grant it.
- IDLE with both req bits set: grant the port that is not last_grant.
- On every grant: update last_grant, go to SETUP, and assert ack[n] during the SETUP cycle only.
- req is ignored outside IDLE. A request raised during init waits until after ready rises.
- Requesters keep req_rs and req_data stable while req is high and un-acked. A requester may present its next write in the cycle after ack.
- Reset asserted mid-transfer: E drops immediately, everything returns to reset values, and the full init sequence reruns.

## Timing
- Grant latency: ack[n] is high in the first cycle after the IDLE edge that sees req[n].
- Normal write: 1 + E_CYCLES + EXEC_CYCLES = 6 cycles from SETUP to IDLE.
- Clear or home write: 1 + E_CYCLES + CLEAR_CYCLES = 162 cycles.
- Minimum back-to-back spacing between SETUP entries is 7 cycles: 6 for the write, plus 1 IDLE.
- ready rises POWERUP_CYCLES + 3×6 + 162 = 1680 cycles after reset release.
- Wait counter width is $clog2(max of all cycle parameters)+1. The counter reloads on each state entry and never wraps.

## Structure
- lcd_pkg holds:
  - the state enum;
  - init command constants, as a 4-entry array;
  - command codes CMD_CLEAR=0x01 and CMD_HOME=0x02;
  - parameter defaults.
- Sub-module lcd_rr_arb2: a 2-input round-robin grant with a last_grant register and an advance strobe.
- The top level ties lcd_bus_arbiter between the requesters and GPIO_0[4:6] and GPIO_0[15:8].

## Test plan
- Reset release, no requests:
  - E stays 0 for 1500 cycles.
  - 4 E pulses follow, with data 0x38, 0x0C, 0x01, 0x06 and RS=0.
  - ready rises at cycle 1680.
- After ready, req=01 with rs=1, byte 0x41:
  - ack=01 for 1 cycle.
  - RS=1 and data=0x41 in SETUP.
  - E high for 1 cycle.
  - Back to IDLE 6 cycles after SETUP.
- req=11 held continuously, port0=0x30 and port1=0x31, both data:
  - First grant goes to port 0, since last_grant=1 at reset.
  - Grants then alternate 0,1,0,1, spaced 7 cycles apart.
- Port 1 writes command 0x01:
  - The WAIT lasts 160 cycles.
  - A port 0 request raised mid-WAIT is acked only after IDLE is reached.
- rst pulsed low while E=1:
  - E=0 and ready=0 asynchronously.
  - The init sequence restarts, with the first E pulse 1500 cycles after release.
- req raised during INIT_WAIT: no ack before ready=1, then ack within 1 cycle.
